// File: rtl/snake_game_core.sv
// Snake engine: grid body shift register, LFSR food placement, IDLE/RUN/OVER FSM.
// Build option: define SNAKE_WALL_WRAP_EN to wrap the head at grid edges instead of dying.
module snake_game_core #(
    parameter int GRID_W   = 8,
    parameter int GRID_H   = 8,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_left,
    input  logic                     btn_right,
    output logic [GRID_W*GRID_H-1:0] pix,
    output logic [6:0]               len,
    output logic [7:0]               score,
    output logic                     playing,
    output logic                     game_over
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

    state_t        state_q;
    dir_t          dir_q, pend_q, pend_d, req;
    logic          req_v;
    logic [XW-1:0] sx_q [MAX_LEN];
    logic [YW-1:0] sy_q [MAX_LEN];
    logic [6:0]    len_q, lim;
    logic [7:0]    score_q, lfsr_q, lfsr_nx;
    logic [XW-1:0] fx_q, nx, cx;
    logic [YW-1:0] fy_q, ny, cy;
    logic          fv_q, playing_q, over_q;
    logic [XW:0]   hx_w;
    logic [YW:0]   hy_w;
    logic          wall_die, eat, hit_body, cand_hit;

    always_comb begin
        req_v = 1'b1;
        req   = dir_q;
        if (btn_up)         req = D_UP;
        else if (btn_down)  req = D_DOWN;
        else if (btn_left)  req = D_LEFT;
        else if (btn_right) req = D_RIGHT;
        else                req_v = 1'b0;
        pend_d = pend_q;
        if (req_v && (req != dir_t'(dir_q ^ 2'b01)))
            pend_d = req;
    end

    // One extra bit catches stepping off either edge.
    always_comb begin
        hx_w = {1'b0, sx_q[0]};
        hy_w = {1'b0, sy_q[0]};
        unique case (pend_q)
            D_RIGHT: hx_w = hx_w + (XW+1)'(1);
            D_LEFT:  hx_w = hx_w - (XW+1)'(1);
            D_UP:    hy_w = hy_w - (YW+1)'(1);
            D_DOWN:  hy_w = hy_w + (YW+1)'(1);
            default: ;
        endcase
        nx = hx_w[XW-1:0];
        ny = hy_w[YW-1:0];
`ifdef SNAKE_WALL_WRAP_EN
        wall_die = 1'b0;
`else
        wall_die = hx_w[XW] | hy_w[YW];
`endif
    end

    always_comb begin
        eat      = fv_q && (nx == fx_q) && (ny == fy_q);
        lim      = eat ? len_q : len_q - 7'd1;
        cx       = lfsr_q[XW-1:0];
        cy       = lfsr_q[XW+YW-1:XW];
        hit_body = 1'b0;
        cand_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((7'(i) < lim) && (sx_q[i] == nx) && (sy_q[i] == ny))
                hit_body = 1'b1;
            if ((7'(i) < len_q) && (sx_q[i] == cx) && (sy_q[i] == cy))
                cand_hit = 1'b1;
        end
        lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_comb begin
        pix = '0;
        for (int i = 0; i < MAX_LEN; i++)
            if (7'(i) < len_q)
                pix[{sy_q[i], sx_q[i]}] = 1'b1;
        if (fv_q)
            pix[{fy_q, fx_q}] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dir_q     <= D_RIGHT;
            pend_q    <= D_RIGHT;
            len_q     <= 7'(INIT_LEN);
            score_q   <= '0;
            fx_q      <= XW'(5);
            fy_q      <= YW'(5);
            fv_q      <= 1'b1;
            lfsr_q    <= 8'h3A;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                sx_q[i] <= XW'(3 - i);
                sy_q[i] <= YW'(3);
            end
        end else if (state_q == S_OVER && start) begin
            state_q   <= S_IDLE;
            dir_q     <= D_RIGHT;
            pend_q    <= D_RIGHT;
            len_q     <= 7'(INIT_LEN);
            score_q   <= '0;
            fx_q      <= XW'(5);
            fy_q      <= YW'(5);
            fv_q      <= 1'b1;
            lfsr_q    <= 8'h3A;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                sx_q[i] <= XW'(3 - i);
                sy_q[i] <= YW'(3);
            end
        end else begin
            pend_q <= pend_d;
            if (state_q == S_IDLE && start) begin
                state_q   <= S_RUN;
                playing_q <= 1'b1;
            end
            if (state_q == S_RUN && tick) begin
                dir_q  <= pend_q;
                lfsr_q <= lfsr_nx;
                if (wall_die || hit_body) begin
                    state_q   <= S_OVER;
                    playing_q <= 1'b0;
                    over_q    <= 1'b1;
                end else begin
                    sx_q[0] <= nx;
                    sy_q[0] <= ny;
                    for (int i = 1; i < MAX_LEN; i++) begin
                        sx_q[i] <= sx_q[i-1];
                        sy_q[i] <= sy_q[i-1];
                    end
                    if (eat) begin
                        if (len_q < 7'(MAX_LEN))
                            len_q <= len_q + 7'd1;
                        if (score_q != 8'hFF)
                            score_q <= score_q + 8'd1;
                        fv_q <= 1'b0;
                    end
                end
            end
            // Food search is suspended in OVER so the final frame stays put.
            if (!fv_q && state_q != S_OVER) begin
                lfsr_q <= lfsr_nx;
                if (!cand_hit) begin
                    fv_q <= 1'b1;
                    fx_q <= cx;
                    fy_q <= cy;
                end
            end
        end
    end

    assign len       = len_q;
    assign score     = score_q;
    assign playing   = playing_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_snake_game_core.sv
// Bench for snake_game_core: queue-based game model, per-cycle compare, random play.
module tb_snake_game_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, start = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [63:0] pix;
    logic [6:0]  len;
    logic [7:0]  score;
    logic        playing, game_over;

    int total = 0;
    int bad = 0;

    snake_game_core dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pix(pix), .len(len), .score(score), .playing(playing), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Model: body as a queue of cell numbers y*8+x, head first.
    int bq[$];
    int mst, mdx, mdy, pdx, pdy, mscore, mfood, mfv, lf;

    task automatic m_init();
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(3 * 8 + ((3 - i + 8) % 8));
        mdx = 1; mdy = 0; pdx = 1; pdy = 0;
        mscore = 0; mfood = 5 * 8 + 5; mfv = 1; lf = 'h3A; mst = 0;
    endtask

    function automatic bit in_body(int c, int n);
        for (int i = 0; i < n && i < bq.size(); i++)
            if (bq[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_step();
        int rx, ry, npdx, npdy, cand, hx, hy, nx, ny, nc;
        bit req, search, cand_free, do_lf, out, eat, hit;
        npdx = pdx; npdy = pdy; req = 1; rx = 0; ry = 0;
        if (btn_up) begin rx = 0; ry = -1; end
        else if (btn_down) begin rx = 0; ry = 1; end
        else if (btn_left) begin rx = -1; ry = 0; end
        else if (btn_right) begin rx = 1; ry = 0; end
        else req = 0;
        if (req && !(rx == -mdx && ry == -mdy)) begin npdx = rx; npdy = ry; end
        search = (mfv == 0) && (mst != 2);
        cand = ((lf / 8) % 8) * 8 + (lf % 8);
        cand_free = !in_body(cand, bq.size());
        do_lf = search;
        if (mst == 2) begin
            if (start) begin m_init(); return; end
        end else if (mst == 0) begin
            if (start) mst = 1;
        end else if (tick) begin
            do_lf = 1;
            hx = bq[0] % 8; hy = bq[0] / 8;
            nx = hx + pdx; ny = hy + pdy;
            out = (nx < 0) || (nx > 7) || (ny < 0) || (ny > 7);
            nx = (nx + 8) % 8; ny = (ny + 8) % 8;
            nc = ny * 8 + nx;
            eat = (mfv != 0) && (nc == mfood);
            hit = in_body(nc, eat ? bq.size() : bq.size() - 1);
`ifndef SNAKE_WALL_WRAP_EN
            if (out) hit = 1;
`endif
            mdx = pdx; mdy = pdy;
            if (hit) mst = 2;
            else begin
                bq.push_front(nc);
                if (eat) begin
                    if (bq.size() > 16) void'(bq.pop_back());
                    if (mscore < 255) mscore++;
                    mfv = 0;
                end else void'(bq.pop_back());
            end
        end
        if (search && cand_free) begin mfv = 1; mfood = cand; end
        if (do_lf) lf = ((lf << 1) | ($countones(lf & 'hB8) & 1)) & 255;
        pdx = npdx; pdy = npdy;
    endtask

    function automatic logic [63:0] m_pix();
        logic [63:0] p = '0;
        foreach (bq[i]) p[bq[i]] = 1'b1;
        if (mfv != 0) p[mfood] = 1'b1;
        return p;
    endfunction

    initial begin
        m_init();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_init();
            else m_step();
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("pix", pix, m_pix());
        chk("len", 64'(len), 64'(bq.size()));
        chk("score", 64'(score), 64'(mscore));
        chk("playing", 64'(playing), 64'(mst == 1));
        chk("game_over", 64'(game_over), 64'(mst == 2));
    end

    // b = {up, down, left, right}
    task automatic step(input logic t, input logic s, input logic [3:0] b);
        tick = t; start = s;
        {btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk); #1;
        tick = 0; start = 0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 0;
        step(0, 0, 4'b0);
        rst_n = 1;
        step(0, 0, 4'b0);
    endtask

    localparam logic [63:0] RST_PIX = 64'h0000_2000_0F00_0000;

    initial begin
        bit got;
        @(posedge clk); #1;
        step(0, 0, 4'b0);
        chk("rst_pix", pix, RST_PIX);
        chk("rst_len", 64'(len), 64'd4);
        chk("rst_score", 64'(score), 64'd0);
        chk("rst_playing", 64'(playing), 64'd0);
        chk("rst_over", 64'(game_over), 64'd0);
        rst_n = 1;
        step(0, 0, 4'b0);

        step(0, 1, 4'b0);
        chk("start_playing", 64'(playing), 64'd1);
        step(1, 0, 4'b0);
        step(0, 0, 4'b0);
        step(1, 0, 4'b0);
        chk("two_moves_pix", pix, 64'h0000_2000_3C00_0000);

        step(0, 0, 4'b0100);
        step(1, 0, 4'b0);
        step(1, 0, 4'b0);
        chk("eat_len", 64'(len), 64'd5);
        chk("eat_score", 64'(score), 64'd1);
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            step(0, 0, 4'b0);
            got = ($countones(pix) == 6);
        end
        chk("food_respawn", 64'(got), 64'd1);

        step(0, 0, 4'b1000);
        step(1, 0, 4'b0);
        step(0, 0, 4'b0010);
        step(1, 0, 4'b0);
        step(0, 0, 4'b1000);
        step(1, 0, 4'b0);
        step(0, 0, 4'b0001);
        step(1, 0, 4'b0);
        chk("self_hit_over", 64'(game_over), 64'd1);
        for (int k = 0; k < 3; k++) step(1, 0, 4'b0);
        step(0, 1, 4'b0);
        chk("reinit_pix", pix, RST_PIX);
        chk("reinit_over", 64'(game_over), 64'd0);
        step(0, 1, 4'b0);
        chk("restart_playing", 64'(playing), 64'd1);

        reset_pulse();
        step(1, 1, 4'b0);
        chk("start_tick_pix", pix, RST_PIX);
        chk("start_tick_playing", 64'(playing), 64'd1);
        for (int k = 0; k < 5; k++) step(1, 0, 4'b0);
`ifdef SNAKE_WALL_WRAP_EN
        chk("wall_pix", pix, 64'h0000_2000_E100_0000);
        chk("wall_over", 64'(game_over), 64'd0);
`else
        chk("wall_pix", pix, 64'h0000_2000_F000_0000);
        chk("wall_over", 64'(game_over), 64'd1);
`endif

        reset_pulse();
        step(0, 1, 4'b0);
        step(1, 0, 4'b0);
        step(1, 0, 4'b0);
        #2 rst_n = 0;
        #1;
        chk("async_pix", pix, RST_PIX);
        chk("async_len", 64'(len), 64'd4);
        chk("async_score", 64'(score), 64'd0);
        chk("async_playing", 64'(playing), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        step(0, 0, 4'b0);

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 699) == 0) begin
                rst_n = 0;
                step(0, 0, 4'b0);
                rst_n = 1;
            end
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
